ascii_number_parser: RTL and testbench

- Serial ASCII-to-binary parser; the inverse of the team's 16-bit number to ASCII hex/binary formatters.
- Consumes one ASCII character per accepted cycle, typically from the UART RX path.
- Accumulates hex digits (4 max) or binary digits (16 max) into a 16-bit value.
- Emits the value with a one-cycle valid pulse; feeds the register/command logic.

---
 rtl/ascii_number_parser.sv | 160 ++++++++++++++++
 tb/tb_ascii_number_parser.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_number_parser.sv
// ascii_number_parser: serial ASCII hex/binary digits -> 16-bit value.
// Numbers complete on reaching the mode's digit limit or on TERM_CHAR.
// Optional feature macro: ASCII_PARSER_LOWERCASE_EN (accept 'a'-'f' as hex).
module ascii_number_parser #(
  parameter int          MAX_HEX_DIGITS = 4,
  parameter int          MAX_BIN_DIGITS = 16,
  parameter logic [7:0]  TERM_CHAR      = 8'h0D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode_bin,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [15:0] number_out,
  output logic        number_valid,
  output logic [4:0]  digit_count,
  output logic        parse_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_mode;
  logic [15:0] r_acc;
  logic [4:0]  r_count;
  logic [15:0] r_number;
  logic        r_valid;
  logic        r_error;
  logic        r_ready;

  logic        w_mode;
  logic        w_is_digit;
  logic [3:0]  w_digit;
  logic        w_is_term;
  logic [15:0] w_base;
  logic [15:0] w_shift;
  logic [4:0]  w_cnt_next;
  logic [4:0]  w_max;
  logic        w_accept;

  assign char_ready   = r_ready;
  assign number_out   = r_number;
  assign number_valid = r_valid;
  assign digit_count  = r_count;
  assign parse_error  = r_error;

  // Classify the incoming character and precompute the shifted accumulator
  always_comb begin
    w_mode     = (r_state == ST_IDLE) ? mode_bin : r_mode;
    w_is_digit = 1'b0;
    w_digit    = 4'd0;
    if (w_mode) begin
      if (char_in == 8'h30) begin
        w_is_digit = 1'b1;
        w_digit    = 4'd0;
      end else if (char_in == 8'h31) begin
        w_is_digit = 1'b1;
        w_digit    = 4'd1;
      end else begin
        w_is_digit = 1'b0;
        w_digit    = 4'd0;
      end
    end else begin
      if (char_in >= 8'h30 && char_in <= 8'h39) begin
        w_is_digit = 1'b1;
        w_digit    = char_in[3:0];
      end else if (char_in >= 8'h41 && char_in <= 8'h46) begin
        w_is_digit = 1'b1;
        w_digit    = char_in[3:0] + 4'd9;
`ifdef ASCII_PARSER_LOWERCASE_EN
      end else if (char_in >= 8'h61 && char_in <= 8'h66) begin
        w_is_digit = 1'b1;
        w_digit    = char_in[3:0] + 4'd9;
`endif
      end else begin
        w_is_digit = 1'b0;
        w_digit    = 4'd0;
      end
    end
    w_is_term  = (char_in == TERM_CHAR);
    // IDLE always starts a fresh number from zero
    w_base     = (r_state == ST_IDLE) ? 16'h0000 : r_acc;
    w_shift    = w_mode ? {w_base[14:0], w_digit[0]} : {w_base[11:0], w_digit};
    w_cnt_next = ((r_state == ST_IDLE) ? 5'd0 : r_count) + 5'd1;
    w_max      = w_mode ? 5'(MAX_BIN_DIGITS) : 5'(MAX_HEX_DIGITS);
    w_accept   = char_valid && r_ready;
  end

  // Parser FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_mode   <= 1'b0;
      r_acc    <= 16'h0000;
      r_count  <= 5'd0;
      r_number <= 16'h0000;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_valid <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (w_accept) begin
            if (w_is_digit) begin
              if (r_state == ST_IDLE) begin
                r_mode <= mode_bin;
              end
              r_acc   <= w_shift;
              r_count <= w_cnt_next;
              if (w_cnt_next == w_max) begin
                r_state  <= ST_DONE;
                r_number <= w_shift;
                r_valid  <= 1'b1;
                r_ready  <= 1'b0;
              end else begin
                r_state <= ST_ACCUM;
              end
            end else if (w_is_term) begin
              // A terminator with no digits collected is silently dropped
              if (r_state == ST_ACCUM) begin
                r_state  <= ST_DONE;
                r_number <= r_acc;
                r_valid  <= 1'b1;
                r_ready  <= 1'b0;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              // Illegal character discards any partial number
              r_error <= 1'b1;
              r_acc   <= 16'h0000;
              r_count <= 5'd0;
              r_state <= ST_IDLE;
            end
          end
        end
        ST_DONE: begin
          r_acc   <= 16'h0000;
          r_count <= 5'd0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_acc   <= 16'h0000;
          r_count <= 5'd0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascii_number_parser.sv
// Scoreboard bench for ascii_number_parser: directed plan plus random chars.
module tb_ascii_number_parser;

  logic        clk;
  logic        rst_n;
  logic        mode_bin;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic [15:0] number_out;
  logic        number_valid;
  logic [4:0]  digit_count;
  logic        parse_error;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic        is_err;
    logic [15:0] val;
  } ev_t;
  ev_t exp_q[$];

  // reference model state
  int          m_count = 0;
  bit          m_mode  = 1'b0;
  int          m_val   = 0;
  logic [15:0] m_out   = 16'h0000;

  ascii_number_parser dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode_bin     (mode_bin),
    .char_in      (char_in),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .number_out   (number_out),
    .number_valid (number_valid),
    .digit_count  (digit_count),
    .parse_error  (parse_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int dval(input logic [7:0] ch, input bit mb);
    if (mb) begin
      if (ch == "0") return 0;
      if (ch == "1") return 1;
      return -1;
    end
    if (ch >= "0" && ch <= "9") return int'(ch) - int'("0");
    if (ch >= "A" && ch <= "F") return int'(ch) - int'("A") + 10;
`ifdef ASCII_PARSER_LOWERCASE_EN
    if (ch >= "a" && ch <= "f") return int'(ch) - int'("a") + 10;
`endif
    return -1;
  endfunction

  task automatic push_num();
    ev_t e;
    e.is_err = 1'b0;
    e.val    = 16'(m_val);
    exp_q.push_back(e);
    m_out   = 16'(m_val);
    m_count = 0;
    m_val   = 0;
  endtask

  task automatic push_err();
    ev_t e;
    e.is_err = 1'b1;
    e.val    = m_out;
    exp_q.push_back(e);
    m_count = 0;
    m_val   = 0;
  endtask

  // behavioural model: digits are accumulated as val*base+d
  task automatic model_accept(input logic [7:0] ch, input bit mb);
    bit mode;
    int d;
    int maxd;
    mode = (m_count == 0) ? mb : m_mode;
    d    = dval(ch, mode);
    maxd = mode ? 16 : 4;
    if (d >= 0) begin
      if (m_count == 0) m_mode = mb;
      m_val = m_val * (mode ? 2 : 16) + d;
      m_count++;
      if (m_count == maxd) push_num();
    end else if (ch == 8'h0D) begin
      if (m_count > 0) push_num();
    end else begin
      push_err();
    end
  endtask

  task automatic send(input logic [7:0] ch, input bit mb);
    int guard;
    guard = 0;
    @(negedge clk);
    char_in    = ch;
    mode_bin   = mb;
    char_valid = 1'b1;
    while (!char_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      chk("send_timeout", 1, 0);
      char_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      char_valid = 1'b0;
      model_accept(ch, mb);
    end
  endtask

  task automatic send_str(input string s, input bit mb);
    for (int i = 0; i < s.len(); i++) send(s[i], mb);
  endtask

  // monitor: pop and compare whenever the DUT pulses an output
  always @(negedge clk) begin
    if (rst_n) begin
      if (number_valid && parse_error) chk("both_pulses", 1, 0);
      if (number_valid || parse_error) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {number_valid, parse_error}, 0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("pulse_kind", int'(parse_error), int'(e.is_err));
          if (!e.is_err) chk("number_out", int'(number_out), int'(e.val));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string hexs;
    string pick;
    int    k;
    hexs       = "0123456789ABCDEF";
    rst_n      = 1'b0;
    mode_bin   = 1'b0;
    char_in    = 8'h00;
    char_valid = 1'b0;
    #12;
    chk("rst_ready", int'(char_ready), 1);
    chk("rst_number", int'(number_out), 0);
    chk("rst_count", int'(digit_count), 0);
    chk("rst_valid", int'(number_valid), 0);
    chk("rst_error", int'(parse_error), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1. hex full
    send_str("1A3", 1'b0);
    chk("hex_count3", int'(digit_count), 3);
    send("F", 1'b0);
    chk("hex_valid", int'(number_valid), 1);
    chk("hex_value", int'(number_out), 16'h1A3F);
    chk("hex_done_ready", int'(char_ready), 0);
    @(posedge clk);
    #1;
    chk("hex_count0", int'(digit_count), 0);
    chk("hex_ready_back", int'(char_ready), 1);

    // 2. early terminator, then lone terminator
    send_str("7C", 1'b0);
    send(8'h0D, 1'b0);
    chk("term_value", int'(number_out), 16'h007C);
    send(8'h0D, 1'b0);
    chk("lone_term_valid", int'(number_valid), 0);
    chk("lone_term_error", int'(parse_error), 0);

    // 3. binary full, then with mode toggling after the first digit
    send_str("1010000011110101", 1'b1);
    chk("bin_value", int'(number_out), 16'hA0F5);
    pick = "1010000011110101";
    for (int i = 0; i < 16; i++) send(pick[i], (i == 0) ? 1'b1 : 1'(i % 2));
    chk("bin_toggle_value", int'(number_out), 16'hA0F5);

    // 4. error discard
    send_str("4G", 1'b0);
    chk("err_pulse", int'(parse_error), 1);
    chk("err_no_valid", int'(number_valid), 0);
    chk("err_held", int'(number_out), 16'hA0F5);
    chk("err_count", int'(digit_count), 0);
    send("2", 1'b0);
    send(8'h0D, 1'b0);
    chk("err_recover", int'(number_out), 16'h0002);

    // 5. backpressure across DONE
    send("7", 1'b0);
    send(8'h0D, 1'b0);
    chk("bp_ready_low", int'(char_ready), 0);
    send("5", 1'b0);
    chk("bp_count", int'(digit_count), 1);
    send(8'h0D, 1'b0);
    chk("bp_value", int'(number_out), 16'h0005);

    // 6. reset mid-number and lowercase handling
    send_str("99", 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_number", int'(number_out), 0);
    chk("mid_rst_count", int'(digit_count), 0);
    chk("mid_rst_ready", int'(char_ready), 1);
    m_count = 0;
    m_val   = 0;
    m_out   = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    send("b", 1'b0);
`ifdef ASCII_PARSER_LOWERCASE_EN
    send_str("eef", 1'b0);
    chk("lower_value", int'(number_out), 16'hBEEF);
`else
    chk("lower_error", int'(parse_error), 1);
`endif
    send("b", 1'b1);
    chk("lower_bin_error", int'(parse_error), 1);

    // random characters against the model
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 9);
      if (k < 4) char_in = hexs[$urandom_range(0, 15)];
      else if (k < 7) char_in = ($urandom_range(0, 1) == 0) ? 8'h30 : 8'h31;
      else if (k == 7) char_in = 8'h0D;
      else if (k == 8) char_in = 8'h61 + 8'($urandom_range(0, 5));
      else char_in = 8'($urandom_range(0, 255));
      send(char_in, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
